// File: rtl/lock_ctrl_pkg.sv
// Shared types for the lock controller: FSM state encoding, the decoded
// command set and the pure functions that map raw inputs to commands and
// commands to the next access state.
package lock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENABLED = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMD_IDLE   = 2'd0,
      CMD_ENABLE = 2'd1,
      CMD_LOCK   = 2'd2
   } cmd_t;

   // {lock_on, enable_all}: 11 is illegal and deliberately folds onto IDLE,
   // so a stuck-high pair can never enable or lock.
   function automatic cmd_t decode_cmd(input logic lock_on, input logic enable_all);
      cmd_t c;
      case ({lock_on, enable_all})
         2'b01:   c = CMD_ENABLE;
         2'b10:   c = CMD_LOCK;
         default: c = CMD_IDLE;
      endcase
      return c;
   endfunction

   // LOCKED absorbs every command; only reset leaves it.
   function automatic state_t next_state(input state_t cur, input cmd_t cmd);
      state_t n;
      if (cur == ST_LOCKED) begin
         n = ST_LOCKED;
      end else begin
         case (cmd)
            CMD_ENABLE: n = ST_ENABLED;
            CMD_LOCK:   n = ST_LOCKED;
            default:    n = ST_IDLE;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/lock_ctrl_fsm_if.sv
// Control/write bundle between the upstream decoder/requester and
// lock_ctrl_fsm.
//   master : drives enable_all, lock_on, wr_req, wr_data; observes status
//   slave  : the controller; drives reg_q, wr_ack, wr_err, is_enabled,
//            is_locked, lock_viol
interface lock_ctrl_fsm_if #(
   parameter int DATA_W = 8
);
   logic              enable_all;
   logic              lock_on;
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] reg_q;
   logic              wr_ack;
   logic              wr_err;
   logic              is_enabled;
   logic              is_locked;
   logic              lock_viol;

   modport master (
      output enable_all, lock_on, wr_req, wr_data,
      input  reg_q, wr_ack, wr_err, is_enabled, is_locked, lock_viol
   );

   modport slave (
      input  enable_all, lock_on, wr_req, wr_data,
      output reg_q, wr_ack, wr_err, is_enabled, is_locked, lock_viol
   );
endinterface

// File: rtl/cmd_qualifier.sv
// Stability filter for the decoded command.
//   clk, rst     : clock, async active-high reset
//   i_cmd        : decoded command, sampled every rising edge
//   o_qual_cmd   : command being qualified (valid when o_qual_fire=1)
//   o_qual_fire  : high in the cycle whose edge is the QUAL_CYCLES-th
//                  consecutive sample of the same command; fires once per run
module cmd_qualifier
   import lock_ctrl_pkg::*;
#(
   parameter int QUAL_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  cmd_t i_cmd,
   output cmd_t o_qual_cmd,
   output logic o_qual_fire
);

   localparam int              CNT_W   = $clog2(QUAL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUAL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   cmd_t             r_last_cmd;
   logic             w_same;

   assign w_same     = (i_cmd == r_last_cmd);
   assign o_qual_cmd = i_cmd;

   // The count lands on CNT_MAX at this edge: either the run continues from
   // CNT_MAX-1, or a fresh run starts and one sample is already enough.
   // Once saturated at CNT_MAX the same command never fires again.
   assign o_qual_fire = w_same ? (r_cnt == (CNT_MAX - CNT_ONE)) : (QUAL_CYCLES == 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_last_cmd <= CMD_IDLE;
      end else if (!w_same) begin
         r_cnt      <= CNT_ONE;
         r_last_cmd <= i_cmd;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt      <= r_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Access controller for a protected config register. The decoded
// enable_all/lock_on pair is stability-qualified, then drives a sticky
// IDLE/ENABLED/LOCKED FSM that gates writes.
//   clk      : clock, all state on rising edge
//   rst      : async active-high reset
//   ctrl_if  : slave side of lock_ctrl_fsm_if (command pair, write request,
//              register contents, ack/err pulses, status flags)
//
// state      | meaning
// ST_IDLE    | writes refused with wr_err
// ST_ENABLED | writes accepted with wr_ack
// ST_LOCKED  | writes refused, lock_viol set; exits only on rst
module lock_ctrl_fsm
   import lock_ctrl_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                QUAL_CYCLES = 4,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
   input logic           clk,
   input logic           rst,
   lock_ctrl_fsm_if.slave ctrl_if
);

   cmd_t              w_cmd;
   cmd_t              w_qual_cmd;
   logic              w_qual_fire;
   state_t            w_next;

   state_t            r_state;
   logic [DATA_W-1:0] r_reg_q;
   logic              r_wr_ack;
   logic              r_wr_err;
   logic              r_is_enabled;
   logic              r_is_locked;
   logic              r_lock_viol;

   assign w_cmd = decode_cmd(ctrl_if.lock_on, ctrl_if.enable_all);

   cmd_qualifier #(
      .QUAL_CYCLES (QUAL_CYCLES)
   ) u_qual (
      .clk         (clk),
      .rst         (rst),
      .i_cmd       (w_cmd),
      .o_qual_cmd  (w_qual_cmd),
      .o_qual_fire (w_qual_fire)
   );

   assign w_next = w_qual_fire ? next_state(r_state, w_qual_cmd) : r_state;

   // Write outcome keys off r_state (pre-transition), so a write on the
   // ENABLED->LOCKED edge still lands and one on IDLE->ENABLED is refused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_reg_q      <= RESET_VAL;
         r_wr_ack     <= 1'b0;
         r_wr_err     <= 1'b0;
         r_is_enabled <= 1'b0;
         r_is_locked  <= 1'b0;
         r_lock_viol  <= 1'b0;
      end else begin
         r_wr_ack <= 1'b0;
         r_wr_err <= 1'b0;
         if (ctrl_if.wr_req) begin
            case (r_state)
               ST_ENABLED: begin
                  r_reg_q  <= ctrl_if.wr_data;
                  r_wr_ack <= 1'b1;
               end
               ST_LOCKED: begin
                  r_wr_err    <= 1'b1;
                  r_lock_viol <= 1'b1;
               end
               default: begin
                  r_wr_err <= 1'b1;
               end
            endcase
         end
         r_state      <= w_next;
         r_is_enabled <= (w_next == ST_ENABLED);
         r_is_locked  <= (w_next == ST_LOCKED);
      end
   end

   assign ctrl_if.reg_q      = r_reg_q;
   assign ctrl_if.wr_ack     = r_wr_ack;
   assign ctrl_if.wr_err     = r_wr_err;
   assign ctrl_if.is_enabled = r_is_enabled;
   assign ctrl_if.is_locked  = r_is_locked;
   assign ctrl_if.lock_viol  = r_lock_viol;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Bench for lock_ctrl_fsm: directed stimulus, a run-length behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_lock_ctrl_fsm;

   localparam int         Q  = 4;
   localparam logic [7:0] RV = 8'hC3;

   logic clk = 1'b0;
   logic rst;
   logic cmp_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   lock_ctrl_fsm_if #(.DATA_W(8)) u_if ();

   lock_ctrl_fsm #(
      .DATA_W      (8),
      .QUAL_CYCLES (Q),
      .RESET_VAL   (RV)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_if (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: state 0=idle 1=enabled 2=locked; command 0=idle 1=enable 2=lock.
   // A command acts when its run of consecutive samples reaches exactly Q.
   int         m_state, m_run, m_last, m_cmd;
   logic [7:0] m_reg;
   logic       m_ack, m_err, m_viol;

   task automatic model_step();
      if (rst) begin
         m_state = 0; m_run = 0; m_last = 0;
         m_reg = RV; m_ack = 1'b0; m_err = 1'b0; m_viol = 1'b0;
      end else begin
         if (u_if.lock_on && !u_if.enable_all)      m_cmd = 2;
         else if (u_if.enable_all && !u_if.lock_on) m_cmd = 1;
         else                                       m_cmd = 0;
         m_run  = (m_cmd == m_last) ? m_run + 1 : 1;
         m_last = m_cmd;
         m_ack  = u_if.wr_req && (m_state == 1);
         m_err  = u_if.wr_req && (m_state != 1);
         if (u_if.wr_req && m_state == 1) m_reg = u_if.wr_data;
         if (u_if.wr_req && m_state == 2) m_viol = 1'b1;
         if (m_run == Q && m_state != 2) m_state = m_cmd;
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   always @(negedge clk) begin
      if (cmp_en) begin
         chk8("m_reg_q",      u_if.reg_q,      m_reg);
         chk1("m_wr_ack",     u_if.wr_ack,     m_ack);
         chk1("m_wr_err",     u_if.wr_err,     m_err);
         chk1("m_is_enabled", u_if.is_enabled, m_state == 1);
         chk1("m_is_locked",  u_if.is_locked,  m_state == 2);
         chk1("m_lock_viol",  u_if.lock_viol,  m_viol);
      end
   end

   task automatic step(input logic en, input logic lk, input logic wr, input logic [7:0] d);
      u_if.enable_all = en;
      u_if.lock_on    = lk;
      u_if.wr_req     = wr;
      u_if.wr_data    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      u_if.enable_all = 1'b0;
      u_if.lock_on    = 1'b0;
      u_if.wr_req     = 1'b0;
      u_if.wr_data    = 8'h00;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk8("rst_reg_q",  u_if.reg_q,      RV);
      chk1("rst_ack",    u_if.wr_ack,     1'b0);
      chk1("rst_err",    u_if.wr_err,     1'b0);
      chk1("rst_en",     u_if.is_enabled, 1'b0);
      chk1("rst_lock",   u_if.is_locked,  1'b0);
      chk1("rst_viol",   u_if.lock_viol,  1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      u_if.enable_all = 1'b0;
      u_if.lock_on    = 1'b0;
      u_if.wr_req     = 1'b0;
      u_if.wr_data    = 8'h00;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      do_reset();

      // enable qualifies on the 4th edge, then a write is accepted
      repeat (3) step(1, 0, 0, 8'h00);
      chk1("t1_not_yet", u_if.is_enabled, 1'b0);
      step(1, 0, 0, 8'h00);
      chk1("t1_enabled", u_if.is_enabled, 1'b1);
      step(1, 0, 1, 8'hA5);
      chk1("t1_ack", u_if.wr_ack, 1'b1);
      chk1("t1_no_err", u_if.wr_err, 1'b0);
      chk8("t1_reg", u_if.reg_q, 8'hA5);
      step(1, 0, 0, 8'h00);
      chk1("t1_ack_pulse", u_if.wr_ack, 1'b0);

      // back-to-back writes, one ack each
      step(1, 0, 1, 8'h11);
      chk8("b2b_reg1", u_if.reg_q, 8'h11);
      step(1, 0, 1, 8'h22);
      chk1("b2b_ack2", u_if.wr_ack, 1'b1);
      step(1, 0, 1, 8'h33);
      chk8("b2b_reg3", u_if.reg_q, 8'h33);
      step(1, 0, 0, 8'h00);

      // short lock glitch has no effect
      repeat (3) step(0, 1, 0, 8'h00);
      repeat (4) step(1, 0, 0, 8'h00);
      chk1("glitch_en", u_if.is_enabled, 1'b1);
      chk1("glitch_lock", u_if.is_locked, 1'b0);

      // illegal 11 acts as IDLE after qualification
      repeat (3) step(1, 1, 0, 8'h00);
      chk1("ill_still_en", u_if.is_enabled, 1'b1);
      step(1, 1, 0, 8'h00);
      chk1("ill_idle", u_if.is_enabled, 1'b0);
      repeat (6) step(1, 1, 0, 8'h00);
      chk1("ill_not_lock", u_if.is_locked, 1'b0);
      step(1, 1, 1, 8'h44);
      chk1("ill_wr_err", u_if.wr_err, 1'b1);
      chk8("ill_reg", u_if.reg_q, 8'h33);

      // 3-edge enable then drop: stays idle, write refused
      do_reset();
      repeat (3) step(1, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 0, 1, 8'h5E);
      chk1("t2_err", u_if.wr_err, 1'b1);
      chk1("t2_en", u_if.is_enabled, 1'b0);
      chk8("t2_reg", u_if.reg_q, RV);

      // write on the IDLE->ENABLED edge is refused
      do_reset();
      repeat (3) step(1, 0, 0, 8'h00);
      step(1, 0, 1, 8'h99);
      chk1("en_edge_err", u_if.wr_err, 1'b1);
      chk1("en_edge_ack", u_if.wr_ack, 1'b0);
      chk1("en_edge_en", u_if.is_enabled, 1'b1);
      chk8("en_edge_reg", u_if.reg_q, RV);

      // write on the ENABLED->LOCKED edge succeeds; next write violates
      step(1, 0, 0, 8'h00);
      repeat (3) step(0, 1, 0, 8'h00);
      chk1("t6_not_locked", u_if.is_locked, 1'b0);
      step(0, 1, 1, 8'h77);
      chk1("t6_ack", u_if.wr_ack, 1'b1);
      chk8("t6_reg", u_if.reg_q, 8'h77);
      chk1("t6_locked", u_if.is_locked, 1'b1);
      chk1("t6_no_viol", u_if.lock_viol, 1'b0);
      step(0, 1, 1, 8'h3C);
      chk1("t3_err", u_if.wr_err, 1'b1);
      chk1("t3_viol", u_if.lock_viol, 1'b1);
      chk8("t3_reg", u_if.reg_q, 8'h77);

      // LOCKED is sticky against IDLE and ENABLE
      repeat (10) step(0, 0, 0, 8'h00);
      chk1("t4_lock_idle", u_if.is_locked, 1'b1);
      repeat (10) step(1, 0, 0, 8'h00);
      chk1("t4_lock_en", u_if.is_locked, 1'b1);
      chk1("t4_not_en", u_if.is_enabled, 1'b0);
      chk1("t4_viol_sticky", u_if.lock_viol, 1'b1);
      step(1, 0, 1, 8'hEE);
      chk1("t4_err", u_if.wr_err, 1'b1);
      chk8("t4_reg", u_if.reg_q, 8'h77);
      do_reset();

      // reset mid-qualification discards the count
      repeat (2) step(1, 0, 0, 8'h00);
      do_reset();
      repeat (3) step(1, 0, 0, 8'h00);
      chk1("midq_not_en", u_if.is_enabled, 1'b0);
      step(1, 0, 0, 8'h00);
      chk1("midq_en", u_if.is_enabled, 1'b1);

      // reset while a write is pending: no ack, register back to reset value
      step(1, 0, 1, 8'h81);
      chk8("midw_reg", u_if.reg_q, 8'h81);
      u_if.wr_req  = 1'b1;
      u_if.wr_data = 8'h18;
      rst = 1'b1;
      #2;
      chk1("midw_no_ack", u_if.wr_ack, 1'b0);
      chk8("midw_reg_rst", u_if.reg_q, RV);
      do_reset();

      step(0, 0, 0, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
